// File: rtl/rr_arbiter16.sv
// 16-requester round-robin arbiter with a bounded grant tenure.
// The one-hot grant vector is decoded from the registered grant index.

module decoder4to16 (
    input  logic [3:0]  a,
    input  logic        en,
    output logic [15:0] y
);

    // One-hot decode of a, gated by en
    always_comb begin
        y = 16'h0000;
        if (en) begin
            y[a] = 1'b1;
        end else begin
            y = 16'h0000;
        end
    end

endmodule

module rr_arbiter16 #(
    parameter int MAX_HOLD = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic        done,
    output logic [3:0]  gnt_idx,
    output logic        gnt_valid,
    output logic [15:0] gnt,
    output logic        busy,
    output logic        timeout
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_GRANT   = 2'b01,
        S_RELEASE = 2'b10
    } state_t;

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

    state_t      state_r, state_n_s;
    logic [3:0]  ptr_r, ptr_n_s;
    logic [7:0]  hold_r, hold_n_s;
    logic [3:0]  gnt_idx_r, gnt_idx_n_s;
    logic        gnt_valid_r, gnt_valid_n_s;
    logic        busy_r, busy_n_s;
    logic        timeout_r, timeout_n_s;
    logic [4:0]  pick_s;
    logic        expire_s;
    logic        exit_s;

    // Returns {found, index}; scanning offsets high-to-low lets the nearest
    // requester after ptr overwrite farther ones, and offset 16 wraps to ptr.
    function automatic logic [4:0] rr_pick(input logic [15:0] r, input logic [3:0] p);
        logic [4:0] res;
        logic [3:0] idx;
        res = 5'b0_0000;
        for (int i = 16; i >= 1; i--) begin
            idx = p + 4'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign pick_s   = rr_pick(req, ptr_r);
    assign expire_s = (hold_r == MAX_HOLD_C);
    assign exit_s   = done | ~req[gnt_idx_r] | expire_s;

    // Next-state and next-output logic
    always_comb begin
        state_n_s     = state_r;
        ptr_n_s       = ptr_r;
        hold_n_s      = hold_r;
        gnt_idx_n_s   = gnt_idx_r;
        gnt_valid_n_s = gnt_valid_r;
        busy_n_s      = busy_r;
        timeout_n_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (pick_s[4]) begin
                    state_n_s     = S_GRANT;
                    gnt_idx_n_s   = pick_s[3:0];
                    hold_n_s      = 8'd1;
                    gnt_valid_n_s = 1'b1;
                    busy_n_s      = 1'b1;
                end else begin
                    state_n_s     = S_IDLE;
                    gnt_idx_n_s   = 4'd0;
                    gnt_valid_n_s = 1'b0;
                    busy_n_s      = 1'b0;
                end
            end
            S_GRANT: begin
                if (exit_s) begin
                    state_n_s     = S_RELEASE;
                    ptr_n_s       = gnt_idx_r;
                    gnt_idx_n_s   = 4'd0;
                    gnt_valid_n_s = 1'b0;
                    busy_n_s      = 1'b1;
                    // Expiry only counts when nothing else ended the tenure
                    timeout_n_s   = expire_s & ~done & req[gnt_idx_r];
                end else if (hold_r < MAX_HOLD_C) begin
                    hold_n_s = hold_r + 8'd1;
                end else begin
                    hold_n_s = hold_r;
                end
            end
            S_RELEASE: begin
                state_n_s     = S_IDLE;
                gnt_idx_n_s   = 4'd0;
                gnt_valid_n_s = 1'b0;
                busy_n_s      = 1'b0;
            end
            default: begin
                state_n_s     = S_IDLE;
                ptr_n_s       = 4'hF;
                hold_n_s      = 8'd0;
                gnt_idx_n_s   = 4'd0;
                gnt_valid_n_s = 1'b0;
                busy_n_s      = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            ptr_r       <= 4'hF;
            hold_r      <= 8'd0;
            gnt_idx_r   <= 4'd0;
            gnt_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            ptr_r       <= ptr_n_s;
            hold_r      <= hold_n_s;
            gnt_idx_r   <= gnt_idx_n_s;
            gnt_valid_r <= gnt_valid_n_s;
            busy_r      <= busy_n_s;
            timeout_r   <= timeout_n_s;
        end
    end

    decoder4to16 u_dec (
        .a  (gnt_idx_r),
        .en (gnt_valid_r),
        .y  (gnt)
    );

    assign gnt_idx   = gnt_idx_r;
    assign gnt_valid = gnt_valid_r;
    assign busy      = busy_r;
    assign timeout   = timeout_r;

endmodule

// File: tb/tb_rr_arbiter16.sv
// Directed bench for rr_arbiter16 (MAX_HOLD=4): expected outputs are queued
// as each step is driven and compared once the clock edge has produced them.

module tb_rr_arbiter16;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic        done;
    logic [3:0]  gnt_idx;
    logic        gnt_valid;
    logic [15:0] gnt;
    logic        busy;
    logic        timeout;

    int total_cnt = 0;
    int bad_cnt   = 0;

    typedef struct {
        string       tag;
        logic        v;
        logic [3:0]  idx;
        logic [15:0] g;
        logic        b;
        logic        to;
    } exp_t;

    exp_t exp_q[$];

    rr_arbiter16 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .gnt       (gnt),
        .busy      (busy),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input string fld, input logic [15:0] obs, input logic [15:0] expv);
        total_cnt++;
        assert (obs === expv) else begin
            bad_cnt++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, expv);
        end
    endtask

    task automatic push(input string tag, input logic v, input logic [3:0] idx, input logic b, input logic to);
        exp_t e;
        logic [15:0] one;
        one   = 16'h0001;
        e.tag = tag;
        e.v   = v;
        e.idx = idx;
        e.g   = v ? (one << idx) : 16'h0000;
        e.b   = b;
        e.to  = to;
        exp_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        total_cnt++;
        assert (exp_q.size() > 0) else begin
            bad_cnt++;
            $error("FAIL queue observed=empty expected=entry");
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.tag, "gnt_valid", {15'd0, gnt_valid}, {15'd0, e.v});
            chk(e.tag, "gnt_idx",   {12'd0, gnt_idx},   {12'd0, e.idx});
            chk(e.tag, "gnt",       gnt,                e.g);
            chk(e.tag, "busy",      {15'd0, busy},      {15'd0, e.b});
            chk(e.tag, "timeout",   {15'd0, timeout},   {15'd0, e.to});
        end
    endtask

    // Drive inputs, queue expectation for the outputs after the next edge.
    task automatic step(input string tag, input logic [15:0] r, input logic d,
                        input logic v, input logic [3:0] idx, input logic b, input logic to);
        req  = r;
        done = d;
        push(tag, v, idx, b, to);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic do_reset();
        req   = 16'h0000;
        done  = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        push("reset", 1'b0, 4'd0, 1'b0, 1'b0);
        pop_check();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        req   = 16'h0000;
        done  = 1'b0;
        #2;
        do_reset();

        // Single requester 0, then drop its request
        step("r0_grant", 16'h0001, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
        step("r0_drop",  16'h0000, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        step("r0_idle",  16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        step("done_idle", 16'h0000, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);

        // All requesting, done each grant: 0..15 then 0 again
        do_reset();
        for (int k = 0; k < 17; k++) begin
            step("rr_grant", 16'hFFFF, 1'b0, 1'b1, 4'(k), 1'b1, 1'b0);
            step("rr_rel",   16'hFFFF, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
            step("rr_idle",  16'hFFFF, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        end

        // Pointer rotation between requesters 3 and 7
        step("p3_grant", 16'h0088, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0);
        step("p3_rel",   16'h0088, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
        step("p3_idle",  16'h0088, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        step("p7_grant", 16'h0088, 1'b0, 1'b1, 4'd7, 1'b1, 1'b0);
        step("p7_rel",   16'h0008, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        step("p7_idle",  16'h0008, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        step("p3b_grant", 16'h0008, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0);
        step("p3b_rel",  16'h0008, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
        step("p3b_idle", 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

        // MAX_HOLD expiry on requester 5, then re-grant
        step("h5_grant", 16'h0020, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step("h5_hold", 16'h0020, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0);
        end
        step("h5_tmo",   16'h0020, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        step("h5_idle",  16'h0020, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        step("h5_regnt", 16'h0020, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0);
        // Other requests toggle; done coincides with expiry -> no timeout
        step("h5_oth1",  16'h0FF0, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0);
        step("h5_oth2",  16'hF03F, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0);
        step("h5_oth3",  16'h0021, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0);
        step("h5_both",  16'h0020, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
        step("h5_idle2", 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

        // Request drop mid-tenure moves the pointer to the served index
        step("d8_grant", 16'h0300, 1'b0, 1'b1, 4'd8, 1'b1, 1'b0);
        step("d8_drop",  16'h0200, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        step("d8_idle",  16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        step("d9_grant", 16'h0300, 1'b0, 1'b1, 4'd9, 1'b1, 1'b0);

        // Asynchronous reset between edges during grant of 9
        req = 16'hFFFF;
        #2;
        rst_n = 1'b0;
        #1;
        push("async_rst", 1'b0, 4'd0, 1'b0, 1'b0);
        pop_check();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        step("post_rst", 16'hFFFF, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
